// File: rtl/shot_pkg.sv
// Shared types and default constants for the player shot scheduler and the
// reusable slot picker.
package shot_pkg;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2
  } shot_state_t;

  localparam int unsigned SHOT_NUM_SLOTS_DEF = 4;
  localparam int unsigned SHOT_COOLDOWN_DEF  = 8;
  localparam int unsigned SHOT_MAX_AMMO_DEF  = 15;
  localparam int unsigned SHOT_RELOAD_DEF    = 30;

  localparam int unsigned SHOT_CNT_W  = 8;
  localparam int unsigned SHOT_AMMO_W = 4;
  localparam int unsigned SHOT_DIR_W  = 3;

endpackage

// File: rtl/rr_free_slot_picker.sv
// Combinational round-robin free-slot picker.
// Scans slot_active starting at rr_ptr (wrapping) and returns the first
// inactive slot.
//   slot_active : occupancy bitmap, 1 = busy
//   rr_ptr      : slot index with highest priority this cycle
//   sel         : chosen free slot (0 when none free)
//   any_free    : at least one slot is free
module rr_free_slot_picker #(
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0]         slot_active,
  input  logic [$clog2(NUM_SLOTS)-1:0] rr_ptr,
  output logic [$clog2(NUM_SLOTS)-1:0] sel,
  output logic                         any_free
);

  localparam int unsigned SEL_W = $clog2(NUM_SLOTS);

  // Walk from lowest to highest priority so the highest-priority free slot wins last.
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    for (int k = int'(NUM_SLOTS) - 1; k >= 0; k--) begin
      if (!slot_active[SEL_W'((int'(rr_ptr) + k) % int'(NUM_SLOTS))]) begin
        sel      = SEL_W'((int'(rr_ptr) + k) % int'(NUM_SLOTS));
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shot_slot_scheduler.sv
// Player shot scheduler: turns each fire press into a one-cycle launch pulse
// on a free mover slot (round-robin), with frame cooldown and a refilling
// ammo budget.
//   clk, reset    : clock, synchronous active-high reset
//   startOfFrame  : one-cycle frame tick
//   fireRequest   : keyboard fire level; rising edge is a press
//   direction_in  : direction handed to the launched shot
//   slot_done     : per-slot end-of-shot pulse
//   triggerShot   : one-hot launch pulse (registered)
//   shotDirection : direction latched at the accepted press (registered)
//   slot_active   : slot occupancy (registered)
//   ammo          : remaining rounds (registered)
//   fire_ready    : combinational, a press right now would be accepted
module shot_slot_scheduler
  import shot_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = SHOT_NUM_SLOTS_DEF,
  parameter int unsigned COOLDOWN_FRAMES = SHOT_COOLDOWN_DEF,
  parameter int unsigned MAX_AMMO        = SHOT_MAX_AMMO_DEF,
  parameter int unsigned RELOAD_FRAMES   = SHOT_RELOAD_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startOfFrame,
  input  logic                   fireRequest,
  input  logic [SHOT_DIR_W-1:0]  direction_in,
  input  logic [NUM_SLOTS-1:0]   slot_done,
  output logic [NUM_SLOTS-1:0]   triggerShot,
  output logic [SHOT_DIR_W-1:0]  shotDirection,
  output logic [NUM_SLOTS-1:0]   slot_active,
  output logic [SHOT_AMMO_W-1:0] ammo,
  output logic                   fire_ready
);

  localparam int unsigned SEL_W = $clog2(NUM_SLOTS);
  localparam logic [SHOT_AMMO_W-1:0] AMMO_FULL   = SHOT_AMMO_W'(MAX_AMMO);
  localparam logic [SHOT_CNT_W-1:0]  CD_LOAD     = SHOT_CNT_W'(COOLDOWN_FRAMES);
  localparam logic [SHOT_CNT_W-1:0]  RL_LAST     = SHOT_CNT_W'(RELOAD_FRAMES - 1);

  shot_state_t           state, state_d;
  logic                  fire_d;
  logic [SEL_W-1:0]      rr_ptr;
  logic [SHOT_CNT_W-1:0] cd_cnt;
  logic [SHOT_CNT_W-1:0] rl_cnt;

  logic                  press;
  logic                  accept;
  logic                  cd_tick;
  logic                  reload_done;
  logic                  any_free;
  logic [SEL_W-1:0]      sel;
  logic [NUM_SLOTS-1:0]  sel_onehot;
  logic [SEL_W-1:0]      rr_next;

  rr_free_slot_picker #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_picker (
    .slot_active (slot_active),
    .rr_ptr      (rr_ptr),
    .sel         (sel),
    .any_free    (any_free)
  );

  assign press       = fireRequest & ~fire_d;
  // any_free is exactly ~&slot_active
  assign fire_ready  = (state == READY) && (ammo != '0) && any_free;
  assign sel_onehot  = NUM_SLOTS'(1) << sel;
  assign rr_next     = SEL_W'((int'(sel) + 1) % int'(NUM_SLOTS));
  assign reload_done = (ammo < AMMO_FULL) && startOfFrame && (rl_cnt >= RL_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= READY;
    else       state <= state_d;
  end

  // Next state; FIRE lasts one cycle and ignores startOfFrame
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    cd_tick = 1'b0;
    unique case (state)
      READY: begin
        if (press && fire_ready) begin
          accept  = 1'b1;
          state_d = FIRE;
        end
      end
      FIRE: state_d = COOLDOWN;
      COOLDOWN: begin
        if (cd_cnt == '0) begin
          state_d = READY;
        end else if (startOfFrame) begin
          cd_tick = 1'b1;
          if (cd_cnt == SHOT_CNT_W'(1)) state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  // Launch side effects are registered on the accepting edge so that the
  // pulse, occupancy and ammo all change together in the FIRE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_d        <= 1'b0;
      triggerShot   <= '0;
      slot_active   <= '0;
      shotDirection <= '0;
      rr_ptr        <= '0;
      cd_cnt        <= '0;
      rl_cnt        <= '0;
      ammo          <= AMMO_FULL;
    end else begin
      fire_d      <= fireRequest;
      triggerShot <= accept ? sel_onehot : '0;
      // Set beats a coincident done pulse on the same slot
      slot_active <= (slot_active & ~slot_done) | (accept ? sel_onehot : '0);

      if (accept) begin
        shotDirection <= direction_in;
        rr_ptr        <= rr_next;
      end

      if (accept)       cd_cnt <= CD_LOAD;
      else if (cd_tick) cd_cnt <= cd_cnt - SHOT_CNT_W'(1);

      if (ammo >= AMMO_FULL)  rl_cnt <= '0;
      else if (reload_done)   rl_cnt <= '0;
      else if (startOfFrame)  rl_cnt <= rl_cnt + SHOT_CNT_W'(1);

      // Fire and reload in the same cycle cancel; both directions saturate
      if (accept && !reload_done && ammo != '0)
        ammo <= ammo - SHOT_AMMO_W'(1);
      else if (reload_done && !accept && ammo < AMMO_FULL)
        ammo <= ammo + SHOT_AMMO_W'(1);
    end
  end

endmodule
